// File: rtl/online_pkg.sv
// online_pkg: shared digit encodings, feeder states and digit normalisation
package online_pkg;

    localparam logic [1:0] DIGIT_POS  = 2'b01;
    localparam logic [1:0] DIGIT_NEG  = 2'b10;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;

    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_SEND,
        FEED_FLUSH
    } feed_state_e;

    // A raw {neg,pos}=11 pair is worth zero and goes out as the canonical 00
    function automatic logic [1:0] norm_digit(input logic neg, input logic pos);
        return (neg && pos) ? DIGIT_ZERO :
               neg          ? DIGIT_NEG  :
               pos          ? DIGIT_POS  : DIGIT_ZERO;
    endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// digit_shift_reg: borrow-save pos/neg word pair with parallel load and shift-left
module digit_shift_reg
    import online_pkg::*;
#(
    parameter int UNROLLING = 64
) (
    input  logic                 clk,
    input  logic                 asyn_reset_n,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [UNROLLING-1:0] pos_i,
    input  logic [UNROLLING-1:0] neg_i,
    output logic [1:0]           msb_o
);

    logic [UNROLLING-1:0] pos_q, neg_q;

    // Load has priority; a shift moves the next digit into the MSB position
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            pos_q <= '0;
            neg_q <= '0;
        end else if (load_i) begin
            pos_q <= pos_i;
            neg_q <= neg_i;
        end else if (shift_i) begin
            pos_q <= {pos_q[UNROLLING-2:0], 1'b0};
            neg_q <= {neg_q[UNROLLING-2:0], 1'b0};
        end
    end

    assign msb_o = norm_digit(neg_q[UNROLLING-1], pos_q[UNROLLING-1]);

endmodule

// File: rtl/online_digit_feeder.sv
// online_digit_feeder: streams a borrow-save operand pair MSB-first into the online multiplier
module online_digit_feeder
    import online_pkg::*;
#(
    parameter int UNROLLING    = 64,
    parameter int ONLINE_DELAY = 2,
    parameter int ADDR_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  asyn_reset_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [UNROLLING-1:0]  x_pos,
    input  logic [UNROLLING-1:0]  x_neg,
    input  logic [UNROLLING-1:0]  y_pos,
    input  logic [UNROLLING-1:0]  y_neg,
    input  logic                  digit_ready,
    output logic                  digit_valid,
    output logic [1:0]            x_digit,
    output logic [1:0]            y_digit,
    output logic                  last_digit,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [3:0]            wr_data,
    output logic                  done,
    output logic                  enc_err
);

    localparam int CW       = $clog2(UNROLLING + ONLINE_DELAY);
    localparam int PAD_LAST = (ONLINE_DELAY > 0) ? ONLINE_DELAY - 1 : 0;
    localparam logic [CW-1:0] SEND_LAST   = CW'(UNROLLING - 1);
    localparam logic [CW-1:0] SEND_PENULT = CW'(UNROLLING - 2);
    localparam logic [CW-1:0] FLUSH_LAST  = CW'(PAD_LAST);

    feed_state_e           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  digit_valid_q, digit_valid_d;
    logic [1:0]            x_digit_q, x_digit_d, y_digit_q, y_digit_d;
    logic                  last_q, last_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  enc_err_q, enc_err_d;
    logic                  load_fire, shift_en, accept, enc_bad;
    logic [1:0]            x_msb, y_msb;

    // The shift registers are loaded pre-shifted: digit 0 goes straight into the
    // output register, so the register MSB is always the digit presented next.
    digit_shift_reg #(.UNROLLING(UNROLLING)) u_x_sr (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .load_i       (load_fire),
        .shift_i      (shift_en),
        .pos_i        ({x_pos[UNROLLING-2:0], 1'b0}),
        .neg_i        ({x_neg[UNROLLING-2:0], 1'b0}),
        .msb_o        (x_msb)
    );

    digit_shift_reg #(.UNROLLING(UNROLLING)) u_y_sr (
        .clk          (clk),
        .asyn_reset_n (asyn_reset_n),
        .load_i       (load_fire),
        .shift_i      (shift_en),
        .pos_i        ({y_pos[UNROLLING-2:0], 1'b0}),
        .neg_i        ({y_neg[UNROLLING-2:0], 1'b0}),
        .msb_o        (y_msb)
    );

    assign accept  = digit_valid_q && digit_ready;
    assign enc_bad = (|(x_pos & x_neg)) || (|(y_pos & y_neg));

    // State register
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) state_q <= FEED_IDLE;
        else               state_q <= state_d;
    end

    // Next state, counter and registered-output next values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        digit_valid_d = digit_valid_q;
        x_digit_d     = x_digit_q;
        y_digit_d     = y_digit_q;
        last_d        = last_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        done_d        = 1'b0;
        enc_err_d     = enc_err_q;
        load_fire     = 1'b0;
        shift_en      = 1'b0;
        case (state_q)
            FEED_IDLE: begin
                if (load_valid) begin
                    load_fire     = 1'b1;
                    state_d       = FEED_SEND;
                    cnt_d         = '0;
                    digit_valid_d = 1'b1;
                    x_digit_d     = norm_digit(x_neg[UNROLLING-1], x_pos[UNROLLING-1]);
                    y_digit_d     = norm_digit(y_neg[UNROLLING-1], y_pos[UNROLLING-1]);
                    last_d        = 1'b0;
                    enc_err_d     = enc_err_q || enc_bad;
                end
            end
            FEED_SEND: begin
                if (accept) begin
                    shift_en  = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(cnt_q);
                    wr_data_d = {x_digit_q, y_digit_q};
                    if (cnt_q == SEND_LAST) begin
                        cnt_d     = '0;
                        x_digit_d = DIGIT_ZERO;
                        y_digit_d = DIGIT_ZERO;
                        if (ONLINE_DELAY == 0) begin
                            state_d       = FEED_IDLE;
                            digit_valid_d = 1'b0;
                            last_d        = 1'b0;
                            done_d        = 1'b1;
                        end else begin
                            state_d = FEED_FLUSH;
                            last_d  = (ONLINE_DELAY == 1);
                        end
                    end else begin
                        cnt_d     = cnt_q + CW'(1);
                        x_digit_d = x_msb;
                        y_digit_d = y_msb;
                        last_d    = (ONLINE_DELAY == 0) && (cnt_q == SEND_PENULT);
                    end
                end
            end
            FEED_FLUSH: begin
                if (accept) begin
                    if (last_q) begin
                        state_d       = FEED_IDLE;
                        cnt_d         = '0;
                        digit_valid_d = 1'b0;
                        last_d        = 1'b0;
                        done_d        = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        last_d = (cnt_q + CW'(1)) == FLUSH_LAST;
                    end
                end
            end
            default: state_d = FEED_IDLE;
        endcase
    end

    // Counter and registered outputs
    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            cnt_q         <= '0;
            digit_valid_q <= 1'b0;
            x_digit_q     <= DIGIT_ZERO;
            y_digit_q     <= DIGIT_ZERO;
            last_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            done_q        <= 1'b0;
            enc_err_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            digit_valid_q <= digit_valid_d;
            x_digit_q     <= x_digit_d;
            y_digit_q     <= y_digit_d;
            last_q        <= last_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
            enc_err_q     <= enc_err_d;
        end
    end

    assign load_ready  = (state_q == FEED_IDLE);
    assign digit_valid = digit_valid_q;
    assign x_digit     = x_digit_q;
    assign y_digit     = y_digit_q;
    assign last_digit  = last_q;
    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign done        = done_q;
    assign enc_err     = enc_err_q;

endmodule
